// File: rtl/pixel_writer_pkg.sv
// Shared types and defaults for the pixel writer.
// Optional write counter enabled by PIXEL_WRITER_COUNT_EN.
package pixel_writer_pkg;

  localparam int PW_ADDR_W = 32;
  localparam int PW_DATA_W = 32;

  typedef enum logic {
    IDLE,
    WRITE
  } pw_state_t;

  typedef struct packed {
    logic [PW_ADDR_W-1:0] addr;
    logic [PW_DATA_W-1:0] data;
  } pw_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding pending pixel writes.
// Push is ignored when full; pop is ignored when empty.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pixel_writer.sv
// Buffers selected pixels and issues them as master writes.
// Define PIXEL_WRITER_COUNT_EN to add the pix_count port.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = PW_ADDR_W,
  parameter int DATA_W = PW_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              found,
  input  logic [ADDR_W-1:0] sel_address,
  input  logic [DATA_W-1:0] sel_data,
  output logic              accept,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_write,
  input  logic              wr_waitrequest,
  output logic              fifo_full,
  output logic              fifo_empty
`ifdef PIXEL_WRITER_COUNT_EN
  ,
  output logic [31:0]       pix_count
`endif
);

  localparam int EW = ADDR_W + DATA_W;

  pw_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_address_q, wr_address_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_write_q, wr_write_d;
  logic              fifo_pop;
  logic [EW-1:0]     head;

  assign accept     = found && !fifo_full;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;
  assign wr_write   = wr_write_q;

  pixel_fifo #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_fifo (
    .clk  (clk),
    .n_rst(n_rst),
    .push (accept),
    .pop  (fifo_pop),
    .din  ({sel_address, sel_data}),
    .head (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    wr_write_d   = wr_write_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          wr_address_d = head[EW-1:DATA_W];
          wr_data_d    = head[DATA_W-1:0];
          wr_write_d   = 1'b1;
          fifo_pop     = 1'b1;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        // Chain the next head straight in to avoid a bubble.
        if (!wr_waitrequest) begin
          if (!fifo_empty) begin
            wr_address_d = head[EW-1:DATA_W];
            wr_data_d    = head[DATA_W-1:0];
            fifo_pop     = 1'b1;
          end else begin
            wr_write_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      wr_address_q <= '0;
      wr_data_q    <= '0;
      wr_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
      wr_write_q   <= wr_write_d;
    end
  end

`ifdef PIXEL_WRITER_COUNT_EN
  logic [31:0] pix_count_q, pix_count_d;

  assign pix_count = pix_count_q;

  always_comb begin
    pix_count_d = pix_count_q + 32'(wr_write_q && !wr_waitrequest);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pix_count_q <= '0;
    else        pix_count_q <= pix_count_d;
  end
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: latency, fill, drain,
// stall hold, pointer wrap and mid-write reset.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        found;
  logic [31:0] sel_address;
  logic [31:0] sel_data;
  logic        accept;
  logic [31:0] wr_address;
  logic [31:0] wr_data;
  logic        wr_write;
  logic        wr_waitrequest;
  logic        fifo_full;
  logic        fifo_empty;
`ifdef PIXEL_WRITER_COUNT_EN
  logic [31:0] pix_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pixel_writer #(
    .DEPTH (4),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .found         (found),
    .sel_address   (sel_address),
    .sel_data      (sel_data),
    .accept        (accept),
    .wr_address    (wr_address),
    .wr_data       (wr_data),
    .wr_write      (wr_write),
    .wr_waitrequest(wr_waitrequest),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty)
`ifdef PIXEL_WRITER_COUNT_EN
    ,
    .pix_count     (pix_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef PIXEL_WRITER_COUNT_EN
    chk(tag, 64'(pix_count), 64'(exp_cnt));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int sent;
    int done;
    logic [31:0] a;

    n_rst = 1'b0;
    found = 1'b0;
    sel_address = '0;
    sel_data = '0;
    wr_waitrequest = 1'b0;

    // reset state
    #2;
    chk("rst_wr_write", 64'(wr_write), 64'd0);
    chk("rst_wr_address", 64'(wr_address), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_empty", 64'(fifo_empty), 64'd1);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk_cnt("rst_pix_count");
    found = 1'b1;
    #1;
    chk("rst_accept", 64'(accept), 64'd1);
    found = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;

    // single pixel latency
    found = 1'b1;
    sel_address = 32'h0000_0040;
    sel_data = 32'hABCD_0001;
    #1;
    chk("single_accept", 64'(accept), 64'd1);
    tick();
    found = 1'b0;
    chk("single_k_write", 64'(wr_write), 64'd0);
    chk("single_k_empty", 64'(fifo_empty), 64'd0);
    tick();
    chk("single_k1_write", 64'(wr_write), 64'd1);
    chk("single_k1_addr", 64'(wr_address), 64'h40);
    chk("single_k1_data", 64'(wr_data), 64'hABCD_0001);
    tick();
    exp_cnt = 1;
    chk("single_k2_write", 64'(wr_write), 64'd0);
    chk("single_k2_empty", 64'(fifo_empty), 64'd1);
    chk_cnt("single_pix_count");

    // fill to full under stall
    wr_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      found = 1'b1;
      sel_address = 32'h100 + 32'(i * 4);
      sel_data = 32'(i);
      #1;
      chk("fill_accept", 64'(accept), 64'd1);
      tick();
    end
    sel_address = 32'h114;
    sel_data = 32'd5;
    #1;
    chk("fill_6th_accept", 64'(accept), 64'd0);
    chk("fill_full", 64'(fifo_full), 64'd1);
    chk("fill_out_addr", 64'(wr_address), 64'h100);
    tick();
    chk("fill_6th_still", 64'(accept), 64'd0);
    chk_cnt("fill_pix_count");

    // back-to-back drain
    found = 1'b0;
    wr_waitrequest = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("drain_write", 64'(wr_write), 64'd1);
      chk("drain_addr", 64'(wr_address), 64'(32'h100 + 32'(j * 4)));
      chk("drain_data", 64'(wr_data), 64'(j));
      tick();
      exp_cnt++;
    end
    chk("drain_idle", 64'(wr_write), 64'd0);
    chk("drain_empty", 64'(fifo_empty), 64'd1);
    chk_cnt("drain_pix_count");

    // stall hold
    wr_waitrequest = 1'b1;
    found = 1'b1;
    sel_address = 32'h200;
    sel_data = 32'h55;
    #1;
    chk("stall_accept", 64'(accept), 64'd1);
    tick();
    found = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      chk("stall_write", 64'(wr_write), 64'd1);
      chk("stall_addr", 64'(wr_address), 64'h200);
      chk("stall_data", 64'(wr_data), 64'h55);
      chk_cnt("stall_pix_count");
      tick();
    end
    wr_waitrequest = 1'b0;
    tick();
    exp_cnt++;
    chk("stall_release", 64'(wr_write), 64'd0);
    chk_cnt("stall_rel_count");

    // pointer wrap: 10 pixels, alternating stall
    sent = 0;
    done = 0;
    for (int c = 0; c < 80 && done < 10; c++) begin
      wr_waitrequest = c[0];
      found = (sent < 10);
      sel_address = 32'h1000 + 32'(sent * 4);
      sel_data = 32'hD000 + 32'(sent);
      #1;
      if (wr_write && !wr_waitrequest) begin
        a = exp_q.pop_front();
        chk("wrap_addr", 64'(wr_address), 64'(a));
        chk("wrap_data", 64'(wr_data),
            64'(32'hD000 + ((a - 32'h1000) >> 2)));
        done++;
      end
      if (found && accept) begin
        exp_q.push_back(sel_address);
        sent++;
      end
      tick();
    end
    found = 1'b0;
    exp_cnt += 10;
    chk("wrap_done", 64'(done), 64'd10);
    chk("wrap_empty", 64'(fifo_empty), 64'd1);
    chk_cnt("wrap_pix_count");

    // reset while stalled with 3 buffered
    wr_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      found = 1'b1;
      sel_address = 32'h300 + 32'(i * 4);
      sel_data = 32'(i);
      tick();
    end
    found = 1'b0;
    chk("mid_write", 64'(wr_write), 64'd1);
    chk("mid_not_empty", 64'(fifo_empty), 64'd0);
    n_rst = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rst_write", 64'(wr_write), 64'd0);
    chk("mid_rst_empty", 64'(fifo_empty), 64'd1);
    chk("mid_rst_addr", 64'(wr_address), 64'd0);
    chk_cnt("mid_rst_count");
    #3;
    n_rst = 1'b1;
    wr_waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_write", 64'(wr_write), 64'd0);
    end
    chk("post_rst_empty", 64'(fifo_empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
